// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants, state encoding and pixel/SAD types for the motion estimator
package me_pkg;

  localparam int MB          = 16;
  localparam int STRIP_W     = 17;
  localparam int N_DY        = 32;
  localparam int SAD_W       = 16;
  localparam int SEARCH_ROWS = MB + N_DY - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef logic [7:0]       pixel_t;
  typedef logic [SAD_W-1:0] sad_t;
  typedef logic [11:0]      row_sad_t;

endpackage

// File: rtl/me_row_sad.sv
// rtl/me_row_sad.sv - combinational sum of absolute differences of two 16-pixel rows
module me_row_sad
  import me_pkg::*;
(
  input  logic [MB*8-1:0] cur_row_i,
  input  logic [MB*8-1:0] ref_row_i,
  output row_sad_t        sad_o
);

  pixel_t a;
  pixel_t b;
  pixel_t diff;

  // Accumulate |a-b| over the row; 16 * 255 fits in 12 bits.
  always_comb begin
    sad_o = '0;
    a     = '0;
    b     = '0;
    diff  = '0;
    for (int l = 0; l < MB; l++) begin
      a     = cur_row_i[l*8 +: 8];
      b     = ref_row_i[l*8 +: 8];
      diff  = (a > b) ? (a - b) : (b - a);
      sad_o = sad_o + {4'b0000, diff};
    end
  end

endmodule

// File: rtl/motion_estimator.sv
// rtl/motion_estimator.sv - full-search 16x16 motion estimator over a 17x47 strip with systolic SAD pipeline
module motion_estimator
  import me_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [127:0]   pixel_cpr_in,
  input  logic [135:0]   pixel_spr_in,
  output logic [5:0]     addr,
  output logic           ready,
  output logic           valid,
  output logic [5:0]     amt,
  output logic [15:0]    min_sad,
  output logic           done
);

  localparam logic [5:0] LOAD_LAST   = 6'(MB - 1);
  localparam logic [5:0] SEARCH_LAST = 6'(SEARCH_ROWS - 1);
  localparam logic [5:0] FIRST_VALID = 6'(SEARCH_ROWS - N_DY);

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [127:0] cur_q [MB];

  // Stages 0..14 are registered; stage 15 is formed combinationally and
  // consumed directly by the min tracker, so it never needs a register.
  sad_t         stage_q [2][MB-1];
  row_sad_t     row_sad [2][MB];
  sad_t         full_sad [2];

  sad_t         min_sad_q;
  logic [5:0]   amt_q;
  logic         cand_dx;
  sad_t         cand_sad;
  logic [4:0]   dy;
  logic         launch;

  assign launch = (state_q == ST_IDLE) && start;

  // One row-SAD unit per stage per horizontal offset; dx selects which 16 strip columns.
  for (genvar dx = 0; dx < 2; dx++) begin : g_dx
    for (genvar k = 0; k < MB; k++) begin : g_stage
      me_row_sad u_row_sad (
        .cur_row_i (cur_q[k]),
        .ref_row_i (pixel_spr_in[dx*8 +: MB*8]),
        .sad_o     (row_sad[dx][k])
      );
    end
    assign full_sad[dx] = stage_q[dx][MB-2] + {4'b0000, row_sad[dx][MB-1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed-length LOAD and SEARCH phases, single DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start)                state_d = ST_LOAD;
      ST_LOAD:   if (cnt_q == LOAD_LAST)   state_d = ST_SEARCH;
      ST_SEARCH: if (cnt_q == SEARCH_LAST) state_d = ST_DONE;
      ST_DONE:                             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Output decode: address follows the row counter only while reading RAMs.
  always_comb begin
    addr  = '0;
    ready = 1'b0;
    valid = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      ST_IDLE:   ready = 1'b1;
      ST_LOAD:   addr  = cnt_q;
      ST_SEARCH: begin
        addr  = cnt_q;
        valid = (cnt_q >= FIRST_VALID);
      end
      ST_DONE:   done  = 1'b1;
      default:   ;
    endcase
  end

  // Row counter restarts at 0 on every phase change.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_LOAD || state_q == ST_SEARCH) && state_d == state_q)
      cnt_d = cnt_q + 6'd1;
  end

  // Row counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Capture the current macroblock one row per LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MB; k++) cur_q[k] <= '0;
    end else if (state_q == ST_LOAD) begin
      cur_q[cnt_q[3:0]] <= pixel_cpr_in;
    end
  end

  // Systolic accumulation: stage k adds current row k against the strip row on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int dx = 0; dx < 2; dx++)
        for (int k = 0; k < MB-1; k++) stage_q[dx][k] <= '0;
    end else if (launch) begin
      for (int dx = 0; dx < 2; dx++)
        for (int k = 0; k < MB-1; k++) stage_q[dx][k] <= '0;
    end else if (state_q == ST_SEARCH) begin
      for (int dx = 0; dx < 2; dx++) begin
        stage_q[dx][0] <= {4'b0000, row_sad[dx][0]};
        for (int k = 1; k < MB-1; k++)
          stage_q[dx][k] <= stage_q[dx][k-1] + {4'b0000, row_sad[dx][k]};
      end
    end
  end

  // dx=0 wins ties between the two candidates of a row; dy wraps correctly in 5 bits.
  assign cand_dx  = (full_sad[1] < full_sad[0]);
  assign cand_sad = cand_dx ? full_sad[1] : full_sad[0];
  assign dy       = cnt_q[4:0] - 5'd15;

  // Running minimum: strict compare keeps the earliest (smallest dy) winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_sad_q <= '1;
      amt_q     <= '0;
    end else if (launch) begin
      min_sad_q <= '1;
      amt_q     <= '0;
    end else if (valid && (cand_sad < min_sad_q)) begin
      min_sad_q <= cand_sad;
      amt_q     <= {cand_dx, dy};
    end
  end

  assign min_sad = min_sad_q;
  assign amt     = amt_q;

endmodule

// File: tb/tb_motion_estimator.sv
// tb/tb_motion_estimator.sv - self-checking bench for motion_estimator
module tb_motion_estimator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] pixel_cpr_in;
  logic [135:0] pixel_spr_in;
  logic [5:0]   addr;
  logic         ready;
  logic         valid;
  logic [5:0]   amt;
  logic [15:0]  min_sad;
  logic         done;

  logic [7:0] cur_mem   [16][16];
  logic [7:0] strip_mem [64][17];

  int checks   = 0;
  int failures = 0;
  int run_sad [32];
  int run_amt [32];

  always #5 clk = ~clk;

  motion_estimator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pixel_cpr_in (pixel_cpr_in),
    .pixel_spr_in (pixel_spr_in),
    .addr         (addr),
    .ready        (ready),
    .valid        (valid),
    .amt          (amt),
    .min_sad      (min_sad),
    .done         (done)
  );

  // Combinational RAM models addressed by the DUT.
  always_comb begin
    pixel_cpr_in = '0;
    pixel_spr_in = '0;
    for (int x = 0; x < 16; x++) pixel_cpr_in[x*8 +: 8] = cur_mem[addr[3:0]][x];
    for (int i = 0; i < 17; i++) pixel_spr_in[i*8 +: 8] = strip_mem[addr][i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [7:0] cv, input logic [7:0] sv);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) cur_mem[y][x] = cv;
    for (int r = 0; r < 64; r++)
      for (int i = 0; i < 17; i++) strip_mem[r][i] = sv;
  endtask

  // Exhaustive search over all 64 displacements, scanning dy then dx in order.
  task automatic model_search();
    int best;
    int bamt;
    int s;
    int d;
    best = 65535;
    bamt = 0;
    for (int dyi = 0; dyi < 32; dyi++) begin
      for (int dxi = 0; dxi < 2; dxi++) begin
        s = 0;
        for (int y = 0; y < 16; y++)
          for (int x = 0; x < 16; x++) begin
            d = int'(strip_mem[dyi+y][dxi+x]) - int'(cur_mem[y][x]);
            s += (d < 0) ? -d : d;
          end
        if (s < best) begin
          best = s;
          bamt = dxi * 32 + dyi;
        end
      end
      run_sad[dyi] = best;
      run_amt[dyi] = bamt;
    end
  endtask

  // Launch a search and check every DUT output on cycles 0..64 against the model.
  task automatic run_search(input string tag, input bit hold);
    int exp_addr;
    int exp_min;
    int exp_amt;
    int d;
    int vcount;
    model_search();
    vcount = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 0; c <= 64; c++) begin
      exp_addr = (c < 16) ? c : ((c < 63) ? c - 16 : 0);
      d = (c - 32 > 31) ? 31 : c - 32;
      exp_min = (c <= 31) ? 65535 : run_sad[d];
      exp_amt = (c <= 31) ? 0 : run_amt[d];
      if (valid === 1'b1) vcount++;
      chk($sformatf("%s addr c%0d", tag, c), 32'(addr), exp_addr);
      chk($sformatf("%s valid c%0d", tag, c), 32'(valid), 32'(c >= 31 && c <= 62));
      chk($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == 63));
      chk($sformatf("%s ready c%0d", tag, c), 32'(ready), 32'(c == 64));
      chk($sformatf("%s min_sad c%0d", tag, c), 32'(min_sad), exp_min);
      chk($sformatf("%s amt c%0d", tag, c), 32'(amt), exp_amt);
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s valid_count", tag), vcount, 32);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    fill(8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready), 1);
    chk("reset valid", 32'(valid), 0);
    chk("reset done", 32'(done), 0);
    chk("reset addr", 32'(addr), 0);
    chk("reset amt", 32'(amt), 0);
    chk("reset min_sad", 32'(min_sad), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Uniform block and strip: every candidate is zero, tie-break keeps (0,0).
    fill(8'h10, 8'h10);
    run_search("flat", 1'b0);
    chk("flat model_sad", run_sad[31], 0);
    chk("flat model_amt", run_amt[31], 0);
    chk("flat final_sad", 32'(min_sad), 0);
    chk("flat final_amt", 32'(amt), 0);
    chk("flat idle_after", 32'(ready), 1);

    // Black block vs white strip: 256 * 255 everywhere.
    fill(8'h00, 8'hFF);
    run_search("contrast", 1'b0);
    chk("contrast model_sad", run_sad[31], 32'hFF00);
    chk("contrast final_sad", 32'(min_sad), 32'hFF00);
    chk("contrast final_amt", 32'(amt), 0);

    // Ramp block embedded at dy=7, dx=1.
    fill(8'h00, 8'hFF);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        cur_mem[y][x] = 8'(y * 16 + x);
        strip_mem[7 + y][1 + x] = 8'(y * 16 + x);
      end
    run_search("ramp", 1'b0);
    chk("ramp model_sad", run_sad[31], 0);
    chk("ramp model_amt", run_amt[31], 32'h27);
    chk("ramp final_sad", 32'(min_sad), 0);
    chk("ramp final_amt", 32'(amt), 32'h27);

    // Column 0 poisoned: dx=1 wins at dy=0.
    fill(8'h10, 8'h10);
    for (int r = 0; r < 47; r++) strip_mem[r][0] = 8'hFF;
    run_search("dx1", 1'b0);
    chk("dx1 model_amt", run_amt[31], 32'h20);
    chk("dx1 final_sad", 32'(min_sad), 0);
    chk("dx1 final_amt", 32'(amt), 32'h20);

    // Start held high: a second search begins in cycle 65.
    fill(8'h00, 8'hFF);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        cur_mem[y][x] = 8'(y * 16 + x);
        strip_mem[7 + y][1 + x] = 8'(y * 16 + x);
      end
    run_search("hold", 1'b1);
    chk("hold c65 ready", 32'(ready), 0);
    chk("hold c65 addr", 32'(addr), 0);
    chk("hold c65 min_sad", 32'(min_sad), 32'hFFFF);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold c66 addr", 32'(addr), 1);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold second_search_idle", 32'(ready), 1);
    chk("hold second_search_amt", 32'(amt), 32'h27);

    // Asynchronous reset during SEARCH row 40.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (56) @(posedge clk);
    #3;
    chk("midrst pre valid", 32'(valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst ready", 32'(ready), 1);
    chk("midrst valid", 32'(valid), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst addr", 32'(addr), 0);
    chk("midrst amt", 32'(amt), 0);
    chk("midrst min_sad", 32'(min_sad), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    fill(8'h00, 8'hFF);
    run_search("after_rst", 1'b0);
    chk("after_rst final_sad", 32'(min_sad), 32'hFF00);
    chk("after_rst final_amt", 32'(amt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_estimator.md
# motion_estimator

Full-search integer motion estimation for one 16x16 macroblock against a 17-column-wide, 47-row search strip. The block loads the current macroblock row by row, then streams search-strip rows through a 16-stage systolic SAD pipeline. It reports the minimum sum of absolute differences (SAD) and its displacement. It sits in the H.264 inter-prediction path between the pixel block RAMs and the mode-decision logic.

## Interface
- MACRO_DIM, 16, macroblock edge in pixels; only the default is supported.
- SEARCH_DIM, 48, search window edge in pixels; only the default is supported.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  level-sampled only in IDLE; starts one search.
- pixel_cpr_in  in  16x8  current-block row at `addr`: element l is column l.
- pixel_spr_in  in  17x8  search-strip row at `addr`: element i is strip column i.
- addr  out  6  shared read address for both RAMs.
- ready  out  1  high only in IDLE.
- valid  out  1  high in cycles where a completed candidate SAD pair is compared.
- amt  out  6  best displacement {dx, dy}: amt[5] is dx (0..1), amt[4:0] is dy (0..31).
- min_sad  out  16  best SAD. Maximum is 256*255 = 65280, so no overflow is possible.
- done  out  1  one-cycle pulse at the end of a search.

## Operation
- RAM read is combinational: data corresponding to `addr` is valid in the same cycle and is captured at the closing edge.
- States are IDLE, LOAD, SEARCH and DONE.
- IDLE
  - addr=0, ready=1.
  - If start=1 at a rising edge: go to LOAD, set min_sad=16'hFFFF and amt=0, and clear all pipeline stages.
- LOAD, 16 cycles, n=0..15
  - addr=n; pixel_cpr_in is stored as current row n in a 16x16 register array.
- SEARCH, 47 cycles, r=0..46
  - addr=r.
  - Stage k (k=0..15), for each dx in {0,1}: next value = stage(k-1) + rowsad(search row r columns dx..dx+15, current row k). Stage −1 is 0.
  - Combinational stage-15 sums are complete SADs for dy=r−15. They are valid when r≥15, giving 32 cycles with valid=1.
- Candidate selection in a valid cycle
  - cand = dx0 sum if sad0 ≤ sad1, else dx1 sum.
  - If cand < min_sad (strict), update min_sad and set amt={dx, r−15}.
  - Ties therefore keep the smallest dy, then dx=0.
- DONE, 1 cycle
  - done=1, addr=0; min_sad and amt are final. Next state is IDLE.
- min_sad and amt
  - Running values are visible during SEARCH.
  - Held from DONE until the next start.
- start is ignored outside IDLE. If start is still high in IDLE after DONE, a new search begins.
- rowsad is the sum of 16 |a−b| terms. Width is 8 bits per difference and 12 bits per row sum; stage registers are 16 bits, unsigned.

## Timing
- Reset values: ready=1, valid=0, done=0, addr=0, amt=0, min_sad=16'hFFFF, state IDLE, pipeline cleared.
- Let cycle 0 be the first cycle after the start-sampling edge.
  - LOAD: cycles 0–15.
  - SEARCH: cycles 16–62.
  - valid: cycles 31–62.
  - done: cycle 63.
  - IDLE: cycle 64.
- Latency from start edge to done is 64 cycles.
- Reset asserted mid-operation returns the block to IDLE immediately and sets all outputs to their reset values. No partial result is kept.
- Search rows 47 and up are never addressed.

## Structure
- Package me_pkg holds:
  - the constants MB=16, STRIP_W=17, N_DY=32 and SAD_W=16;
  - the state enum;
  - the pixel and SAD typedefs.
- Sub-module me_row_sad: combinational SAD of two 16-pixel rows producing 12 bits. It has 32 instances, one per stage per dx.
- The top level holds the FSM, address counter, current-block registers, stage registers and min tracker.

## Test plan
- Reset only → ready=1, valid=0, done=0, addr=0, amt=0, min_sad=16'hFFFF.
- Current block and strip all 8'h10 → min_sad=0, amt=6'h00 (tie-break keeps dy=0, dx=0).
- Current block all 8'h00, strip all 8'hFF → min_sad=16'hFF00, amt=6'h00.
- Current block pixel (y,x)=y*16+x; strip all 8'hFF except that block copied at rows 7..22, columns 1..16 → min_sad=0, amt=6'h27.
- Timing, start pulsed for 1 cycle:
  - addr sequence is 0..15 then 0..46.
  - valid is high exactly 32 cycles.
  - done is high only in cycle 63.
  - With start held high, a second search begins in cycle 65.
- rst_n low during SEARCH cycle 40 → all outputs at reset values asynchronously. After release, a start completes a full, correct search.
